// File: rtl/apb_spi_flash_xip.sv
`timescale 1ns/1ps
// APB3 slave mapping a SPI NOR flash window for execute-in-place word reads.
// Owns a mode-0 SPI shift engine and a one-word read buffer.
module apb_spi_flash_xip #(
    parameter logic [31:0] FLASH_BASE   = 32'h3000_0000,
    parameter int          ADDR_BITS    = 24,
    parameter int          CS_NUM       = 2,
    parameter int          CS_SEL       = 0,
    parameter int          CLK_DIV      = 2,
    parameter int          DUMMY_CYCLES = 0
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic [31:0]       paddr,
    input  logic              psel,
    input  logic              penable,
    input  logic              pwrite,
    input  logic [31:0]       pwdata,
    input  logic [3:0]        pstrb,
    input  logic [2:0]        pprot,
    output logic              pready,
    output logic [31:0]       prdata,
    output logic              pslverr,
    output logic              spi_sck,
    output logic [CS_NUM-1:0] spi_cs,
    output logic              spi_mosi,
    input  logic              spi_miso,
    output logic              busy
);

    localparam int NBITS = 8 + ADDR_BITS + DUMMY_CYCLES + 32;
    localparam int TX_W  = 8 + ADDR_BITS;
    localparam int TAG_W = ADDR_BITS - 2;
    localparam int DIV_W = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
    localparam int BIT_W = $clog2(NBITS);

    localparam logic [7:0]       CMD_C       = (DUMMY_CYCLES == 0) ? 8'h03 : 8'h0B;
    localparam logic [DIV_W-1:0] HALF_C      = DIV_W'(CLK_DIV / 2);
    localparam logic [DIV_W-1:0] HALF_LAST_C = DIV_W'(CLK_DIV / 2 - 1);
    localparam logic [DIV_W-1:0] DIV_LAST_C  = DIV_W'(CLK_DIV - 1);
    localparam logic [BIT_W-1:0] BIT_LAST_C  = BIT_W'(NBITS - 1);
    localparam logic [BIT_W-1:0] RX_FIRST_C  = BIT_W'(NBITS - 32);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CS_SETUP,
        ST_SHIFT,
        ST_CS_HOLD,
        ST_RESP
    } state_t;

    function automatic logic [31:0] byte_swap(input logic [31:0] w);
        return {w[7:0], w[15:8], w[23:16], w[31:24]};
    endfunction

    state_t            state_q, state_d;
    logic [DIV_W-1:0]  div_q, div_d;
    logic [BIT_W-1:0]  bit_q, bit_d;
    logic [TX_W-1:0]   tx_q, tx_d;
    logic [31:0]       rx_q, rx_d;
    logic [TAG_W-1:0]  addr_q, addr_d;
    logic [TAG_W-1:0]  tag_q, tag_d;
    logic [31:0]       buf_q, buf_d;
    logic              valid_q, valid_d;

    logic              err_d;
    logic [31:0]       rdata_d;
    logic              sck_d, mosi_d;
    logic [CS_NUM-1:0] cs_d;

    logic              pready_q, pslverr_q, sck_q, mosi_q, busy_q;
    logic [31:0]       prdata_q;
    logic [CS_NUM-1:0] cs_q;

    logic [31:0]       offset_s;
    logic              in_range_s;
    logic              unused_s;

    assign offset_s   = paddr - FLASH_BASE;
    assign in_range_s = (paddr >= FLASH_BASE) && ((offset_s >> ADDR_BITS) == 32'h0);
    assign unused_s   = ^{pwdata, pstrb, pprot};

    // Next-state logic; the decode of a new access is resolved in the accepting
    // cycle so hits and errors answer on the very next cycle.
    always_comb begin
        state_d = state_q;
        div_d   = div_q;
        bit_d   = bit_q;
        tx_d    = tx_q;
        rx_d    = rx_q;
        addr_d  = addr_q;
        tag_d   = tag_q;
        buf_d   = buf_q;
        valid_d = valid_q;
        err_d   = 1'b0;
        rdata_d = 32'h0;
        case (state_q)
            ST_IDLE: begin
                if (psel && penable) begin
                    if (pwrite || !in_range_s) begin
                        state_d = ST_RESP;
                        err_d   = 1'b1;
                    end else if (valid_q && (tag_q == paddr[ADDR_BITS-1:2])) begin
                        state_d = ST_RESP;
                        rdata_d = buf_q;
                    end else begin
                        state_d = ST_CS_SETUP;
                        addr_d  = paddr[ADDR_BITS-1:2];
                        div_d   = {DIV_W{1'b0}};
                        tx_d    = {CMD_C, paddr[ADDR_BITS-1:2], 2'b00};
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_CS_SETUP: begin
                if (div_q == HALF_LAST_C) begin
                    state_d = ST_SHIFT;
                    div_d   = {DIV_W{1'b0}};
                    bit_d   = {BIT_W{1'b0}};
                end else begin
                    div_d = div_q + DIV_W'(1);
                end
            end
            ST_SHIFT: begin
                // miso is captured in the cycle where SCK is first high
                if ((div_q == HALF_C) && (bit_q >= RX_FIRST_C)) begin
                    rx_d = {rx_q[30:0], spi_miso};
                end else begin
                    rx_d = rx_q;
                end
                if (div_q == DIV_LAST_C) begin
                    div_d = {DIV_W{1'b0}};
                    if (bit_q == BIT_LAST_C) begin
                        state_d = ST_CS_HOLD;
                    end else begin
                        bit_d = bit_q + BIT_W'(1);
                        tx_d  = {tx_q[TX_W-2:0], 1'b1};
                    end
                end else begin
                    div_d = div_q + DIV_W'(1);
                end
            end
            ST_CS_HOLD: begin
                if (div_q == HALF_LAST_C) begin
                    state_d = ST_RESP;
                    rdata_d = byte_swap(rx_q);
                    buf_d   = byte_swap(rx_q);
                    tag_d   = addr_q;
                    valid_d = 1'b1;
                end else begin
                    div_d = div_q + DIV_W'(1);
                end
            end
            ST_RESP: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // SPI pin values derived from the upcoming state so the pins are registered.
    always_comb begin
        cs_d   = {CS_NUM{1'b1}};
        sck_d  = 1'b0;
        mosi_d = 1'b1;
        if ((state_d == ST_CS_SETUP) || (state_d == ST_SHIFT) || (state_d == ST_CS_HOLD)) begin
            cs_d[CS_SEL] = 1'b0;
        end else begin
            cs_d[CS_SEL] = 1'b1;
        end
        if (state_d == ST_SHIFT) begin
            sck_d = (div_d >= HALF_C);
        end else begin
            sck_d = 1'b0;
        end
        if ((state_d == ST_CS_SETUP) || (state_d == ST_SHIFT)) begin
            mosi_d = tx_d[TX_W-1];
        end else begin
            mosi_d = 1'b1;
        end
    end

    // FSM, shift engine and read buffer state.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= ST_IDLE;
            div_q   <= {DIV_W{1'b0}};
            bit_q   <= {BIT_W{1'b0}};
            tx_q    <= {TX_W{1'b0}};
            rx_q    <= 32'h0;
            addr_q  <= {TAG_W{1'b0}};
            tag_q   <= {TAG_W{1'b0}};
            buf_q   <= 32'h0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            div_q   <= div_d;
            bit_q   <= bit_d;
            tx_q    <= tx_d;
            rx_q    <= rx_d;
            addr_q  <= addr_d;
            tag_q   <= tag_d;
            buf_q   <= buf_d;
            valid_q <= valid_d;
        end
    end

    // Registered bus and SPI outputs; response fields are zero outside RESP.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            pready_q  <= 1'b0;
            pslverr_q <= 1'b0;
            prdata_q  <= 32'h0;
            sck_q     <= 1'b0;
            cs_q      <= {CS_NUM{1'b1}};
            mosi_q    <= 1'b1;
            busy_q    <= 1'b0;
        end else begin
            pready_q  <= (state_d == ST_RESP);
            pslverr_q <= err_d;
            prdata_q  <= rdata_d;
            sck_q     <= sck_d;
            cs_q      <= cs_d;
            mosi_q    <= mosi_d;
            busy_q    <= (state_d != ST_IDLE);
        end
    end

    // A master that abandoned the transfer never sees the late ready.
    assign pready   = pready_q & psel;
    assign pslverr  = pslverr_q;
    assign prdata   = prdata_q;
    assign spi_sck  = sck_q;
    assign spi_cs   = cs_q;
    assign spi_mosi = mosi_q;
    assign busy     = busy_q;

endmodule

// File: tb/tb_apb_spi_flash_xip.sv
`timescale 1ns/1ps
// Bench for apb_spi_flash_xip: two instances (default timing, and 8 dummy cycles
// at CLK_DIV=4) against a behavioural SPI flash and a word-buffer reference model.
module tb_apb_spi_flash_xip;

    localparam logic [31:0] BASE = 32'h3000_0000;
    localparam int NI = 2;

    logic clk = 1'b0;
    logic resetn;
    always #5 clk = ~clk;

    logic [31:0] paddr_s   [NI];
    logic        psel_s    [NI];
    logic        penable_s [NI];
    logic        pwrite_s  [NI];
    logic        pready_s  [NI];
    logic        pslverr_s [NI];
    logic [31:0] prdata_s  [NI];
    logic        sck_s     [NI];
    logic [1:0]  cs_s      [NI];
    logic        mosi_s    [NI];
    logic        busy_s    [NI];

    logic        mvalid [NI];
    logic [21:0] mtag   [NI];
    logic [31:0] pool   [4];

    int checks;
    int errors;

    function automatic logic [7:0] flash_byte(input logic [23:0] a);
        case (a)
            24'h000100: return 8'h11;
            24'h000101: return 8'h22;
            24'h000102: return 8'h33;
            24'h000103: return 8'h44;
            default:    return 8'(a[7:0] * 8'd7) ^ a[15:8] ^ a[23:16] ^ 8'h5A;
        endcase
    endfunction

    function automatic logic [31:0] exp_word(input logic [31:0] pa);
        logic [23:0] al;
        al = {pa[23:2], 2'b00};
        return {flash_byte(al + 24'd3), flash_byte(al + 24'd2), flash_byte(al + 24'd1), flash_byte(al)};
    endfunction

    genvar g;
    generate
        for (g = 0; g < NI; g++) begin : g_inst
            localparam int DIV = (g == 0) ? 2 : 4;
            localparam int DUM = (g == 0) ? 0 : 8;

            logic miso_q;
            apb_spi_flash_xip #(
                .FLASH_BASE(BASE), .ADDR_BITS(24), .CS_NUM(2), .CS_SEL(0),
                .CLK_DIV(DIV), .DUMMY_CYCLES(DUM)
            ) u_dut (
                .clk(clk), .resetn(resetn),
                .paddr(paddr_s[g]), .psel(psel_s[g]), .penable(penable_s[g]), .pwrite(pwrite_s[g]),
                .pwdata(32'hDEAD_BEEF), .pstrb(4'hF), .pprot(3'b000),
                .pready(pready_s[g]), .prdata(prdata_s[g]), .pslverr(pslverr_s[g]),
                .spi_sck(sck_s[g]), .spi_cs(cs_s[g]), .spi_mosi(mosi_s[g]), .spi_miso(miso_q),
                .busy(busy_s[g])
            );

            wire sck_w  = sck_s[g];
            wire csn_w  = cs_s[g][0];
            wire cs1_w  = cs_s[g][1];
            wire mosi_w = mosi_s[g];

            int          bitn;
            int          sck_rises;
            int          cs_falls;
            int          other_cs;
            int          dummy_ones;
            int          data_ones;
            logic [7:0]  cmd;
            logic [23:0] addr;
            int          k_s;
            logic [7:0]  cur_byte_s;

            assign k_s        = bitn - 32 - DUM;
            assign cur_byte_s = flash_byte(addr + 24'(k_s / 8));

            // Flash receive side: command, address, dummy and data-phase mosi.
            always @(posedge sck_w or posedge csn_w) begin
                if (csn_w) begin
                    bitn <= 0;
                end else begin
                    if (bitn < 8) cmd <= {cmd[6:0], mosi_w};
                    else if (bitn < 32) addr <= {addr[22:0], mosi_w};
                    else if (bitn < 32 + DUM) dummy_ones <= dummy_ones + {31'd0, mosi_w};
                    else data_ones <= data_ones + {31'd0, mosi_w};
                    bitn <= bitn + 1;
                end
            end

            // Flash transmit side: next data bit after each falling SCK.
            always @(negedge sck_w) begin
                if (!csn_w && k_s >= 0) miso_q <= cur_byte_s[3'(7 - k_s % 8)];
                else miso_q <= 1'b0;
            end

            always @(posedge sck_w) sck_rises <= sck_rises + 1;
            always @(negedge csn_w) cs_falls <= cs_falls + 1;
            always @(negedge cs1_w) other_cs <= other_cs + 1;
        end
    endgenerate

    function automatic int sck_cnt(input int i);
        if (i == 0) return g_inst[0].sck_rises; else return g_inst[1].sck_rises;
    endfunction
    function automatic int csf_cnt(input int i);
        if (i == 0) return g_inst[0].cs_falls; else return g_inst[1].cs_falls;
    endfunction
    function automatic int ocs_cnt(input int i);
        if (i == 0) return g_inst[0].other_cs; else return g_inst[1].other_cs;
    endfunction
    function automatic int dum_cnt(input int i);
        if (i == 0) return g_inst[0].dummy_ones; else return g_inst[1].dummy_ones;
    endfunction
    function automatic int dat_cnt(input int i);
        if (i == 0) return g_inst[0].data_ones; else return g_inst[1].data_ones;
    endfunction
    function automatic logic [7:0] cmd_of(input int i);
        if (i == 0) return g_inst[0].cmd; else return g_inst[1].cmd;
    endfunction
    function automatic logic [23:0] addr_of(input int i);
        if (i == 0) return g_inst[0].addr; else return g_inst[1].addr;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One APB transfer; lat counts cycles from T0 to the cycle pready is seen.
    task automatic apb_xfer(input int i, input logic [31:0] a, input logic wr,
                            output logic [31:0] rd, output logic err, output int lat,
                            output logic after_s);
        @(posedge clk); #1;
        paddr_s[i] = a; pwrite_s[i] = wr; psel_s[i] = 1'b1; penable_s[i] = 1'b0;
        @(posedge clk); #1;
        penable_s[i] = 1'b1;
        lat = 0;
        @(negedge clk);
        while (!pready_s[i] && lat < 1000) begin
            @(negedge clk);
            lat++;
        end
        rd  = prdata_s[i];
        err = pslverr_s[i];
        @(posedge clk); #1;
        penable_s[i] = 1'b0;
        @(negedge clk);
        after_s = pready_s[i] | busy_s[i];
        @(posedge clk); #1;
        psel_s[i] = 1'b0; pwrite_s[i] = 1'b0;
    endtask

    // Reference: outcome, latency, data and SPI traffic from the buffer model.
    task automatic do_read(input int i, input logic [31:0] a, input logic wr);
        logic [31:0] rd;
        logic er, aft, err_e, hit_e, miss_e;
        int lat, lat_e, s0, c0, d0, t0, dum, div, nb;
        dum = (i == 0) ? 0 : 8;
        div = (i == 0) ? 2 : 4;
        nb  = 64 + dum;
        err_e  = wr || (a < BASE) || (a >= BASE + 32'h0100_0000);
        hit_e  = !err_e && mvalid[i] && (mtag[i] == a[23:2]);
        miss_e = !err_e && !hit_e;
        lat_e  = miss_e ? 1 + (nb + 1) * div : 1;
        s0 = sck_cnt(i); c0 = csf_cnt(i); d0 = dum_cnt(i); t0 = dat_cnt(i);
        apb_xfer(i, a, wr, rd, er, lat, aft);
        check("latency", lat, lat_e);
        check("prdata", rd, err_e ? 32'h0 : exp_word(a));
        check("pslverr", {31'd0, er}, {31'd0, err_e});
        check("ready_after", {31'd0, aft}, 32'd0);
        check("sck_rises", sck_cnt(i) - s0, miss_e ? nb : 0);
        check("cs_frames", csf_cnt(i) - c0, miss_e ? 1 : 0);
        if (miss_e) begin
            check("cmd", {24'd0, cmd_of(i)}, (dum == 0) ? 32'h03 : 32'h0B);
            check("spi_addr", {8'd0, addr_of(i)}, {8'd0, a[23:2], 2'b00});
            check("dummy_ones", dum_cnt(i) - d0, dum);
            check("data_ones", dat_cnt(i) - t0, 32);
            mvalid[i] = 1'b1;
            mtag[i]   = a[23:2];
        end
    endtask

    initial begin
        #5000000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        int n_v, seen_v, ocs0_v, ocs1_v, sel_v;
        logic [31:0] a_v;
        checks = 0; errors = 0;
        pool[0] = 32'h0000_0100; pool[1] = 32'h0000_0104;
        pool[2] = 32'h0000_2000; pool[3] = 32'h00FF_FFFC;
        resetn = 1'b0;
        for (int i = 0; i < NI; i++) begin
            psel_s[i] = 1'b0; penable_s[i] = 1'b0; pwrite_s[i] = 1'b0; paddr_s[i] = 32'h0;
            mvalid[i] = 1'b0; mtag[i] = 22'h0;
        end
        repeat (4) @(posedge clk);
        @(negedge clk);
        for (int i = 0; i < NI; i++) begin
            check("rst_pready", {31'd0, pready_s[i]}, 32'd0);
            check("rst_pslverr", {31'd0, pslverr_s[i]}, 32'd0);
            check("rst_prdata", prdata_s[i], 32'd0);
            check("rst_sck", {31'd0, sck_s[i]}, 32'd0);
            check("rst_cs", {30'd0, cs_s[i]}, 32'd3);
            check("rst_mosi", {31'd0, mosi_s[i]}, 32'd1);
            check("rst_busy", {31'd0, busy_s[i]}, 32'd0);
        end
        resetn = 1'b1;
        ocs0_v = ocs_cnt(0); ocs1_v = ocs_cnt(1);

        // Directed: first miss, repeat hit, errors, boundaries.
        do_read(0, BASE + 32'h100, 1'b0);
        check("tp_word", exp_word(BASE + 32'h100), 32'h4433_2211);
        do_read(0, BASE + 32'h102, 1'b0);
        do_read(0, BASE, 1'b1);
        do_read(0, 32'h4000_0000, 1'b0);
        do_read(0, BASE - 32'h4, 1'b0);
        do_read(0, BASE + 32'h0100_0000, 1'b0);
        do_read(1, BASE + 32'h100, 1'b0);
        do_read(1, BASE + 32'h101, 1'b0);
        do_read(0, BASE + 32'h00FF_FFFC, 1'b0);
        do_read(0, BASE, 1'b0);

        // psel dropped mid-frame: frame completes, pready stays gated, buffer fills.
        @(posedge clk); #1;
        paddr_s[0] = BASE + 32'h200; pwrite_s[0] = 1'b0; psel_s[0] = 1'b1; penable_s[0] = 1'b0;
        @(posedge clk); #1;
        penable_s[0] = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        psel_s[0] = 1'b0; penable_s[0] = 1'b0;
        seen_v = 0; n_v = 0;
        do begin
            @(negedge clk);
            if (pready_s[0]) seen_v++;
            n_v++;
        end while (busy_s[0] && n_v < 1000);
        check("drop_pready", seen_v, 0);
        check("drop_done", {31'd0, busy_s[0]}, 32'd0);
        mvalid[0] = 1'b1; mtag[0] = 22'h80;
        do_read(0, BASE + 32'h200, 1'b0);

        // Randomized mix of hits, misses, writes and out-of-window reads.
        for (int it = 0; it < 24; it++) begin
            sel_v = int'($urandom_range(0, 7));
            a_v = BASE + pool[$urandom_range(0, 3)] + 32'($urandom_range(0, 3));
            if (sel_v == 1) a_v = BASE + 32'h0100_0000 + 32'($urandom_range(0, 4095));
            else if (sel_v == 2) a_v = BASE - 32'h1 - 32'($urandom_range(0, 4095));
            do_read(0, a_v, sel_v == 0);
        end

        // Reset pulse during SHIFT with SCK high.
        do_read(0, BASE + 32'h100, 1'b0);
        @(posedge clk); #1;
        paddr_s[0] = BASE + 32'h300; psel_s[0] = 1'b1; penable_s[0] = 1'b0;
        @(posedge clk); #1;
        penable_s[0] = 1'b1;
        repeat (40) @(posedge clk);
        n_v = 0;
        do begin
            @(negedge clk);
            n_v++;
        end while (sck_s[0] !== 1'b1 && n_v < 8);
        check("pre_rst_sck", {31'd0, sck_s[0]}, 32'd1);
        check("pre_rst_cs", {30'd0, cs_s[0]}, 32'd2);
        #2;
        resetn = 1'b0;
        #1;
        check("mid_rst_cs", {30'd0, cs_s[0]}, 32'd3);
        check("mid_rst_sck", {31'd0, sck_s[0]}, 32'd0);
        check("mid_rst_busy", {31'd0, busy_s[0]}, 32'd0);
        @(posedge clk); #1;
        psel_s[0] = 1'b0; penable_s[0] = 1'b0;
        @(negedge clk);
        resetn = 1'b1;
        mvalid[0] = 1'b0; mvalid[1] = 1'b0;
        do_read(0, BASE + 32'h100, 1'b0);
        do_read(1, BASE + 32'h100, 1'b0);

        check("other_cs0", ocs_cnt(0) - ocs0_v, 0);
        check("other_cs1", ocs_cnt(1) - ocs1_v, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
